// File: rtl/msk_prng_pkg.sv
// Shared constants and types for the masking-randomness LFSR feed.
package msk_prng_pkg;
  localparam int LFSR_W = 64;
  localparam int TAP_A  = 63;
  localparam int TAP_B  = 62;
  localparam int TAP_C  = 60;
  localparam int TAP_D  = 59;

  // An all-zero LFSR never leaves zero, so a zero seed is replaced with this value.
  localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = 64'h1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } prng_fsm_t;
endpackage

// File: rtl/msk_lfsr_step.sv
// Combinational NRND-fold advance of the 64-bit Fibonacci LFSR.
// Zero latency; no flow control.
module msk_lfsr_step
  import msk_prng_pkg::*;
#(
  parameter int NRND = 4
) (
  input  logic [LFSR_W-1:0] state_cur,
  output logic [LFSR_W-1:0] state_nxt
);
  logic [LFSR_W-1:0] s;

  // Each shift sees the partially shifted value, exactly as NRND serial clocks would.
  always_comb begin
    s = state_cur;
    for (int i = 0; i < NRND; i++) begin
      s = {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
    end
    state_nxt = s;
  end
endmodule

// File: rtl/msk_prng_feed.sv
// Seedable LFSR feeding fresh randomness to masked AND gadgets; WARMUP cycles from seed to first word.
// Steps only on consumption (en) in RUN; seeds are refused while warming up.
module msk_prng_feed
  import msk_prng_pkg::*;
#(
  parameter int          NRND            = 4,
  parameter int          WARMUP          = 16,
  parameter logic [31:0] RESEED_INTERVAL = 32'd65536
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LFSR_W-1:0] seed,
  input  logic              seed_valid,
  output logic              seed_ready,
  input  logic              en,
  output logic [NRND-1:0]   rnd,
  output logic              rnd_valid,
  output logic              reseed_req,
  output logic              seed_err
);
  localparam logic [31:0] WARMUP_LD = 32'(WARMUP - 1);

  prng_fsm_t         fsm;
  logic [LFSR_W-1:0] state;
  logic [LFSR_W-1:0] state_step;
  logic [31:0]       wcnt;
  logic [31:0]       rcnt;
  logic              seed_acc;

  msk_lfsr_step #(.NRND(NRND)) u_step (
    .state_cur (state),
    .state_nxt (state_step)
  );

  assign seed_acc = seed_valid && seed_ready;
  assign rnd      = state[NRND-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm        <= ST_IDLE;
      state      <= '0;
      wcnt       <= '0;
      rcnt       <= '0;
      rnd_valid  <= 1'b0;
      reseed_req <= 1'b0;
      seed_err   <= 1'b0;
      seed_ready <= 1'b1;
    end else begin
      seed_err <= 1'b0;
      // A seed accepted in RUN pre-empts a simultaneous consumption step.
      if (seed_acc) begin
        state      <= (seed == '0) ? ZERO_SEED_SUB : seed;
        seed_err   <= (seed == '0);
        wcnt       <= WARMUP_LD;
        rcnt       <= '0;
        reseed_req <= 1'b0;
        fsm        <= ST_WARMUP;
        rnd_valid  <= 1'b0;
        seed_ready <= 1'b0;
      end else begin
        case (fsm)
          ST_WARMUP: begin
            state <= state_step;
            if (wcnt == '0) begin
              fsm        <= ST_RUN;
              rnd_valid  <= 1'b1;
              seed_ready <= 1'b1;
            end else begin
              wcnt <= wcnt - 32'd1;
            end
          end
          ST_RUN: begin
            if (en) begin
              state <= state_step;
              if (rcnt != '1) begin
                rcnt <= rcnt + 32'd1;
                if (rcnt + 32'd1 == RESEED_INTERVAL) reseed_req <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_msk_prng_feed.sv
// Randomised bench for msk_prng_feed against a phase-level reference model.
module tb_msk_prng_feed;
  localparam int          NRND = 4;
  localparam int          WU   = 1;
  localparam logic [31:0] RI   = 32'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] seed;
  logic        seed_valid;
  logic        seed_ready;
  logic        en;
  logic [NRND-1:0] rnd;
  logic        rnd_valid;
  logic        reseed_req;
  logic        seed_err;

  int n_chk = 0;
  int n_err = 0;

  msk_prng_feed #(.NRND(NRND), .WARMUP(WU), .RESEED_INTERVAL(RI)) dut (
    .clk        (clk),
    .rst        (rst),
    .seed       (seed),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready),
    .en         (en),
    .rnd        (rnd),
    .rnd_valid  (rnd_valid),
    .reseed_req (reseed_req),
    .seed_err   (seed_err)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 = unseeded, 1 = warming up, 2 = producing words.
  int          m_phase;
  int          m_left;
  longint      m_used;
  bit          m_req;
  bit          m_err;
  logic [63:0] m_state;

  function automatic logic [63:0] lfsr_adv(input logic [63:0] s, input int n);
    logic [63:0] v;
    v = s;
    for (int k = 0; k < n; k++) v = (v << 1) | 64'(v[63] ^ v[62] ^ v[60] ^ v[59]);
    return v;
  endfunction

  task automatic mdl_reset();
    m_phase = 0; m_left = 0; m_used = 0; m_req = 0; m_err = 0; m_state = '0;
  endtask

  task automatic mdl_edge();
    bit acc;
    acc   = seed_valid && (m_phase != 1);
    m_err = 0;
    if (acc) begin
      m_state = (seed == 64'd0) ? 64'd1 : seed;
      m_err   = (seed == 64'd0);
      m_left  = WU;
      m_phase = 1;
      m_used  = 0;
      m_req   = 0;
    end else if (m_phase == 1) begin
      m_state = lfsr_adv(m_state, NRND);
      m_left  = m_left - 1;
      if (m_left == 0) m_phase = 2;
    end else if (m_phase == 2 && en) begin
      m_state = lfsr_adv(m_state, NRND);
      m_used  = m_used + 1;
      if (m_used >= longint'(RI)) m_req = 1;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("rnd",        64'(rnd),        64'(m_state[NRND-1:0]));
    chk("rnd_valid",  64'(rnd_valid),  64'(m_phase == 2));
    chk("seed_ready", 64'(seed_ready), 64'(m_phase != 1));
    chk("reseed_req", 64'(reseed_req), 64'(m_req));
    chk("seed_err",   64'(seed_err),   64'(m_err));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) mdl_edge();
    #1;
    check_all();
  endtask

  task automatic mid_reset();
    #2 rst = 1'b1;
    #1;
    mdl_reset();
    check_all();
    chk("rst_state", dut.state, 64'd0);
    #1 rst = 1'b0;
  endtask

  logic [63:0]     s_new;
  logic [NRND-1:0] held;

  initial begin
    rst = 1'b1; seed_valid = 1'b0; en = 1'b0; seed = '0;
    mdl_reset();
    #2;
    check_all();
    repeat (2) tick();
    rst = 1'b0;

    en = 1'b1;
    repeat (5) tick();
    chk("idle_state", dut.state, 64'd0);
    chk("idle_ready", 64'(seed_ready), 64'd1);
    chk("idle_valid", 64'(rnd_valid), 64'd0);

    en = 1'b0; seed = 64'h0123_4567_89AB_CDEF; seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
    chk("load_state", dut.state, 64'h0123_4567_89AB_CDEF);
    chk("warm_valid", 64'(rnd_valid), 64'd0);
    tick();
    chk("first_valid", 64'(rnd_valid), 64'd1);
    chk("first_state", dut.state, 64'h1234_5678_9ABC_DEF1);
    chk("first_rnd", 64'(rnd), 64'h1);

    held = rnd;
    repeat (10) begin
      tick();
      chk("hold_rnd", 64'(rnd), 64'(held));
    end
    en = 1'b1;
    repeat (2) tick();
    chk("req_before", 64'(reseed_req), 64'd0);
    tick();
    en = 1'b0;
    chk("req_set", 64'(reseed_req), 64'd1);
    repeat (3) tick();
    chk("req_sticky", 64'(reseed_req), 64'd1);

    seed = 64'hDEAD_BEEF_0BAD_F00D; seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
    chk("req_cleared", 64'(reseed_req), 64'd0);
    chk("reseed_drop", 64'(rnd_valid), 64'd0);
    tick();
    chk("reseed_valid", 64'(rnd_valid), 64'd1);

    seed = 64'd0; seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
    chk("zero_state", dut.state, 64'd1);
    chk("zero_err_hi", 64'(seed_err), 64'd1);
    tick();
    chk("zero_err_lo", 64'(seed_err), 64'd0);
    chk("zero_warm_state", dut.state, 64'h10);

    en = 1'b1;
    repeat (2) tick();
    seed = 64'hA5A5_5A5A_C3C3_3C3C; seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0; en = 1'b0;
    chk("simul_state", dut.state, 64'hA5A5_5A5A_C3C3_3C3C);
    tick();
    en = 1'b1;
    repeat (2) tick();
    chk("simul_no_count", 64'(reseed_req), 64'd0);
    tick();
    chk("simul_req_third", 64'(reseed_req), 64'd1);
    en = 1'b0;

    seed = 64'h1111_2222_3333_4444; seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
    mid_reset();
    tick();
    chk("post_rst_idle", dut.state, 64'd0);
    chk("post_rst_valid", 64'(rnd_valid), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      seed_valid = ($urandom_range(0, 15) == 0);
      seed = ($urandom_range(0, 5) == 0) ? 64'd0 : {$urandom, $urandom};
      en = ($urandom_range(0, 3) != 0);
      tick();
      if ($urandom_range(0, 499) == 0) mid_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/msk_prng_feed.md
# msk_prng_feed

Fresh-randomness source for first-order masked AND gadgets using the GHPC low-latency style, each of which consumes 4 random bits in the cycle its input sharings are presented. The block is a seedable 64-bit Fibonacci LFSR advanced NRND steps per consumed word. It has a seed handshake, a warm-up phase, consumption-gated stepping and a reseed-request counter. It sits directly upstream of the gadget's `rnd` input.

## Interface
Parameters:
- `NRND`, 4: random bits delivered per word; legal range 1..32.
- `WARMUP`, 16: LFSR steps discarded after each seed load; must be ≥1.
- `RESEED_INTERVAL`, 32'd65536: consumed words before `reseed_req` rises; must be ≥1.

Ports:
- `clk`, input, 1: single clock, all state on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `seed`, input, 64: seed value.
- `seed_valid`, input, 1: seed offered.
- `seed_ready`, output, 1: seed can be accepted.
- `en`, input, 1: downstream gadget consumes `rnd` this cycle.
- `rnd`, output, NRND: random word, equal to `state[NRND-1:0]`, driven from a register.
- `rnd_valid`, output, 1: `rnd` is usable, high only in RUN.
- `reseed_req`, output, 1: sticky request for a new seed.
- `seed_err`, output, 1: one-cycle pulse when an all-zero seed was accepted.

## Operation
- FSM states: IDLE (unseeded), WARMUP, RUN.
- A seed is accepted when `seed_valid && seed_ready`.
- `seed_ready` is 1 in IDLE and RUN and 0 in WARMUP.
- Seed accept:
  - `state` loads `seed`. If `seed == 0`, it loads 64'h1 instead and `seed_err` pulses the next cycle.
  - The warm-up counter loads `WARMUP-1`, the FSM goes to WARMUP, and the reseed counter and `reseed_req` clear.
- Step: NRND single-bit shifts unrolled in one cycle.
  - Each shift is `state <= {state[62:0], fb}` with `fb = state[63]^state[62]^state[60]^state[59]`, evaluated on the partially shifted value.
- WARMUP:
  - Steps every cycle regardless of `en`; the counter decrements.
  - On the cycle the counter is 0, the FSM steps once more and goes to RUN. This gives exactly WARMUP steps in total.
- RUN:
  - Steps only when `en=1`, so each word is used once. With `en=0`, `rnd` holds.
  - Each `en=1` cycle increments the 32-bit reseed counter, which saturates at all-ones.
  - When the counter reaches `RESEED_INTERVAL`, `reseed_req` is set. The block keeps producing words.
- Reseed in RUN: the seed is accepted as above and the FSM returns to WARMUP, so `rnd_valid` drops for WARMUP cycles.
- Simultaneous seed accept and `en=1` in RUN: the seed load wins and the consumption step is dropped. The word `rnd` shown that cycle is still the valid old word.
- `en` in IDLE or WARMUP is ignored and does not count.

## Timing
- Reset values, applied immediately on `rst` high:
  - FSM = IDLE, `state` = 0, `rnd` = 0, `rnd_valid` = 0.
  - `reseed_req` = 0, `seed_err` = 0, `seed_ready` = 1.
  - All counters = 0.
- Reset mid-WARMUP or mid-RUN: the seed and all progress are discarded and a new seed is required.
- Seed-accept edge to `rnd_valid` = 1 takes WARMUP cycles.
- `rnd` changes exactly one cycle after an `en=1` cycle in RUN, matching the gadget registering `rnd` on that same edge.
- `reseed_req` rises on the edge that completes the RESEED_INTERVAL-th consumed word.

## Structure
- Shared package `msk_prng_pkg` holds:
  - LFSR width 64 and the tap indices {63, 62, 60, 59}.
  - The zero-seed replacement constant 64'h1.
  - The FSM state enum {IDLE, WARMUP, RUN}.
- One sub-module, `msk_lfsr_step`: purely combinational, parameterised by NRND, mapping a 64-bit state to the state after NRND shifts.
- The top level contains the FSM, the counters and the handshake.

## Test plan
- Reset, then idle for 5 cycles with `en=1` → `rnd_valid` = 0, `rnd` = 0, `seed_ready` = 1, no state change.
- WARMUP=1, NRND=4, seed 64'h0123_4567_89AB_CDEF accepted → one cycle later `rnd_valid` = 1, internal state = 64'h1234_5678_9ABC_DEF1, `rnd` = 4'h1.
- Seed 64'h0 accepted → `seed_err` high for exactly one cycle, state loaded as 64'h1, warm-up proceeds normally.
- In RUN, hold `en=0` for 10 cycles then `en=1` for 3 cycles → `rnd` constant for the 10 cycles, three distinct successive step values after.
- RESEED_INTERVAL=3 with `en=1` continuously → `reseed_req` rises after the 3rd consumed word and stays high. A new seed clears it, with `rnd_valid` low for WARMUP cycles.
- Assert `rst` during WARMUP → all outputs take their reset values asynchronously and the FSM returns to IDLE. Seed accept and `en=1` on the same RUN cycle → new seed loaded and the reseed counter does not increment.
